// File: rtl/mem_issue_queue_pkg.sv
// Shared types, opcodes and ROB-age helper for the in-order memory issue queue.
package mem_issue_queue_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam int MEM_IQ_DEPTH  = 32'd8;
   localparam int MEM_IQ_NUM_WB = 32'd3;
   localparam int ROB_SIZE      = 32'd16;
   localparam int ROB_TAG_W     = 32'd5;
   localparam int PREG_W        = 32'd7;

   typedef struct packed {
      logic [6:0]           opcode;
      logic [31:0]          imm;
      logic [PREG_W-1:0]    ps1;
      logic [PREG_W-1:0]    ps2;
      logic [PREG_W-1:0]    pd;
      logic [ROB_TAG_W-1:0] rob_index;
   } rs_data;

   typedef struct packed {
      rs_data data;
      logic   valid;
      logic   rdy1;
      logic   rdy2;
   } mem_iq_entry;

   // Distance of a tag from the ROB head, i.e. how young the op is.
   function automatic logic [ROB_TAG_W-1:0] rob_age(input logic [ROB_TAG_W-1:0] tag,
                                                    input logic [ROB_TAG_W-1:0] head);
      logic [ROB_TAG_W-1:0] diff;
      diff = tag - head;
      return diff & ROB_TAG_W'(ROB_SIZE - 32'sd1);
   endfunction

endpackage

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue: wakeup tracking, oldest-first issue, mispredict flush.
// Optional macro MEM_IQ_WAKEUP_BYPASS_EN lets the head issue in the cycle of its last wakeup.
module mem_issue_queue
   import mem_issue_queue_pkg::*;
#(
   parameter int DEPTH    = MEM_IQ_DEPTH,
   parameter int NUM_WB   = MEM_IQ_NUM_WB,
   parameter int ROB_SIZE = mem_issue_queue_pkg::ROB_SIZE
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               dispatch_valid,
   input  rs_data                             dispatch_data,
   input  logic                               dispatch_ps1_ready,
   input  logic                               dispatch_ps2_ready,
   output logic                               dispatch_ready,
   input  logic [NUM_WB-1:0]                  wb_valid,
   input  logic [NUM_WB-1:0][PREG_W-1:0]      wb_pd,
   input  logic [ROB_TAG_W-1:0]               rob_head,
   input  logic                               mispredict,
   input  logic [ROB_TAG_W-1:0]               mispredict_tag,
   input  logic                               fu_mem_ready,
   output logic                               issued,
   output rs_data                             issue_data,
   output logic [$clog2(DEPTH):0]             count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]         FULL_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]         ONE_CNT  = (PTR_W+1)'(32'd1);
   localparam logic [PTR_W-1:0]       ONE_PTR  = PTR_W'(32'd1);
   localparam logic [ROB_TAG_W-1:0]   AGE_MASK = ROB_TAG_W'(ROB_SIZE - 32'sd1);

   mem_iq_entry          q_r [DEPTH];
   logic [PTR_W-1:0]     head_r;
   logic [PTR_W-1:0]     tail_r;
   logic [PTR_W:0]       count_r;

   logic [DEPTH-1:0]     wake1_s;
   logic [DEPTH-1:0]     wake2_s;
   logic [DEPTH-1:0]     kill_s;
   logic [PTR_W:0]       survivors_s;
   logic [ROB_TAG_W-1:0] flush_age_s;
   logic                 disp_fire_s;
   logic                 head_rdy1_s;
   logic                 head_rdy2_s;
   mem_iq_entry          head_e_s;
   mem_iq_entry          new_e_s;

   function automatic logic wb_hit(input logic [PREG_W-1:0]             ps,
                                   input logic [NUM_WB-1:0]             v,
                                   input logic [NUM_WB-1:0][PREG_W-1:0] pd);
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < NUM_WB; p++) begin
         if (v[p] && (pd[p] != {PREG_W{1'b0}}) && (pd[p] == ps)) begin
            hit = 1'b1;
         end else begin
            hit = hit;
         end
      end
      return hit;
   endfunction

   // Ages are measured from the ROB head so the comparison survives tag wrap.
   assign flush_age_s = rob_age(mispredict_tag, rob_head) & AGE_MASK;

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      assign wake1_s[i] = q_r[i].valid && wb_hit(q_r[i].data.ps1, wb_valid, wb_pd);
      assign wake2_s[i] = q_r[i].valid && wb_hit(q_r[i].data.ps2, wb_valid, wb_pd);
      assign kill_s[i]  = q_r[i].valid &&
                          ((rob_age(q_r[i].data.rob_index, rob_head) & AGE_MASK) > flush_age_s);
   end

   // Number of entries that survive a flush; they form a prefix from the head.
   always_comb begin
      survivors_s = {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         if (q_r[i].valid && !kill_s[i]) begin
            survivors_s = survivors_s + ONE_CNT;
         end else begin
            survivors_s = survivors_s;
         end
      end
   end

   assign dispatch_ready = (count_r < FULL_CNT) && !mispredict;
   assign disp_fire_s    = dispatch_valid && dispatch_ready;
   assign count          = count_r;

   // Entry image for a dispatch, including wakeups landing in the same cycle.
   always_comb begin
      new_e_s.data  = dispatch_data;
      new_e_s.valid = 1'b1;
      new_e_s.rdy1  = dispatch_ps1_ready || (dispatch_data.ps1 == {PREG_W{1'b0}}) ||
                      wb_hit(dispatch_data.ps1, wb_valid, wb_pd);
      new_e_s.rdy2  = dispatch_ps2_ready || (dispatch_data.ps2 == {PREG_W{1'b0}}) ||
                      (dispatch_data.opcode == OPC_LOAD) ||
                      wb_hit(dispatch_data.ps2, wb_valid, wb_pd);
   end

   // Head issue decision; the head alone may issue, so younger ops never bypass it.
   always_comb begin
      head_e_s = q_r[head_r];
`ifdef MEM_IQ_WAKEUP_BYPASS_EN
      head_rdy1_s = head_e_s.rdy1 || wake1_s[head_r];
      head_rdy2_s = head_e_s.rdy2 || wake2_s[head_r];
`else
      head_rdy1_s = head_e_s.rdy1;
      head_rdy2_s = head_e_s.rdy2;
`endif
      issued = head_e_s.valid && head_rdy1_s && head_rdy2_s && fu_mem_ready && !mispredict;
      if (head_e_s.valid) begin
         issue_data = head_e_s.data;
      end else begin
         issue_data = '0;
      end
   end

   // Queue state: wakeups, flush, dispatch write and issue retire.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {(PTR_W+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            q_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            q_r[i].rdy1 <= q_r[i].rdy1 | wake1_s[i];
            q_r[i].rdy2 <= q_r[i].rdy2 | wake2_s[i];
         end
         if (mispredict) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (kill_s[i]) begin
                  q_r[i].valid <= 1'b0;
               end
            end
            tail_r  <= head_r + survivors_s[PTR_W-1:0];
            count_r <= survivors_s;
         end else begin
            if (issued) begin
               q_r[head_r].valid <= 1'b0;
               head_r            <= head_r + ONE_PTR;
            end
            if (disp_fire_s) begin
               q_r[tail_r] <= new_e_s;
               tail_r      <= tail_r + ONE_PTR;
            end
            case ({disp_fire_s, issued})
               2'b10:   count_r <= count_r + ONE_CNT;
               2'b01:   count_r <= count_r - ONE_CNT;
               default: count_r <= count_r;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Scoreboard bench for mem_issue_queue: ops are queued as dispatched and checked in issue order.
module tb_mem_issue_queue;
   import mem_issue_queue_pkg::*;

   localparam int DEPTH  = 8;
   localparam int NUM_WB = 3;
`ifdef MEM_IQ_WAKEUP_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                         clk = 1'b0;
   logic                         reset = 1'b1;
   logic                         dispatch_valid = 1'b0;
   rs_data                       dispatch_data = '0;
   logic                         dispatch_ps1_ready = 1'b0;
   logic                         dispatch_ps2_ready = 1'b0;
   logic                         dispatch_ready;
   logic [NUM_WB-1:0]            wb_valid = '0;
   logic [NUM_WB-1:0][6:0]       wb_pd = '0;
   logic [4:0]                   rob_head = 5'd0;
   logic                         mispredict = 1'b0;
   logic [4:0]                   mispredict_tag = 5'd0;
   logic                         fu_mem_ready = 1'b0;
   logic                         issued;
   rs_data                       issue_data;
   logic [3:0]                   count;

   rs_data sb[$];
   rs_data mon_exp;
   int     total = 0;
   int     bad = 0;

   mem_issue_queue #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .ROB_SIZE(16)) dut (
      .clk(clk), .reset(reset),
      .dispatch_valid(dispatch_valid), .dispatch_data(dispatch_data),
      .dispatch_ps1_ready(dispatch_ps1_ready), .dispatch_ps2_ready(dispatch_ps2_ready),
      .dispatch_ready(dispatch_ready),
      .wb_valid(wb_valid), .wb_pd(wb_pd), .rob_head(rob_head),
      .mispredict(mispredict), .mispredict_tag(mispredict_tag),
      .fu_mem_ready(fu_mem_ready),
      .issued(issued), .issue_data(issue_data), .count(count)
   );

   always #5 clk = ~clk;

   // Every issue must present the oldest op still owed by the scoreboard.
   always @(negedge clk) begin
      if (!reset && issued) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_order: issued %h but no op expected", issue_data);
         end else begin
            mon_exp = sb.pop_front();
            if (issue_data !== mon_exp) begin
               bad++;
               $display("FAIL sb_order: got=%h exp=%h", issue_data, mon_exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dispatch_valid = 1'b0;
      wb_valid       = '0;
      mispredict     = 1'b0;
   endtask

   function automatic rs_data mk_op(input logic [6:0] opc, input logic [6:0] p1,
                                    input logic [6:0] p2, input logic [6:0] pd,
                                    input logic [4:0] rob);
      rs_data r;
      r.opcode    = opc;
      r.imm       = $urandom;
      r.ps1       = p1;
      r.ps2       = p2;
      r.pd        = pd;
      r.rob_index = rob;
      return r;
   endfunction

   task automatic drive_dispatch(input rs_data op, input logic r1, input logic r2, input bit accept);
      dispatch_valid     = 1'b1;
      dispatch_data      = op;
      dispatch_ps1_ready = r1;
      dispatch_ps2_ready = r2;
      if (accept) sb.push_back(op);
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got=%0d exp=0", count); end
      total++; if (dispatch_ready !== 1'b1) begin bad++; $display("FAIL reset_dready: got=%b exp=1", dispatch_ready); end
      total++; if (issued !== 1'b0) begin bad++; $display("FAIL reset_issued: got=%b exp=0", issued); end
      total++; if (issue_data !== '0) begin bad++; $display("FAIL reset_data: got=%h exp=0", issue_data); end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_load();
      fu_mem_ready = 1'b1;
      drive_dispatch(mk_op(OPC_LOAD, 7'd5, 7'd9, 7'd33, 5'd2), 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      total++; if (issued !== 1'b0) begin bad++; $display("FAIL load_c0_issued: got=%b exp=0", issued); end
      tick();
      idle();
      @(negedge clk);
      total++; if (issued !== 1'b1) begin bad++; $display("FAIL load_c1_issued: got=%b exp=1", issued); end
      total++; if (count !== 4'd1) begin bad++; $display("FAIL load_c1_count: got=%0d exp=1", count); end
      tick();
      @(negedge clk);
      total++; if (count !== 4'd0) begin bad++; $display("FAIL load_c2_count: got=%0d exp=0", count); end
      tick();
   endtask

   task automatic test_store_wakeup();
      logic exp_iss;
      fu_mem_ready = 1'b1;
      drive_dispatch(mk_op(OPC_STORE, 7'd0, 7'd12, 7'd0, 5'd3), 1'b0, 1'b0, 1'b1);
      tick();
      idle();
      for (int c = 1; c <= 4; c++) begin
         wb_valid = '0;
         if (c == 2) begin wb_valid = 3'b100; wb_pd[2] = 7'd13; end
         if (c == 3) begin wb_valid = 3'b001; wb_pd[0] = 7'd12; end
         @(negedge clk);
         exp_iss = BYPASS ? (c == 3) : (c == 4);
         total++;
         if (issued !== exp_iss) begin
            bad++; $display("FAIL store_wake_c%0d: issued=%b exp=%b", c, issued, exp_iss);
         end
         tick();
      end
      idle();
      @(negedge clk);
      total++; if (count !== 4'd0) begin bad++; $display("FAIL store_wake_count: got=%0d exp=0", count); end
      tick();
   endtask

   task automatic test_full_wrap();
      fu_mem_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         drive_dispatch(mk_op(OPC_LOAD, 7'd0, 7'd0, 7'(40 + k), 5'(k)), 1'b1, 1'b1, 1'b1);
         tick();
      end
      idle();
      @(negedge clk);
      total++; if (count !== 4'd8) begin bad++; $display("FAIL full_count: got=%0d exp=8", count); end
      total++; if (dispatch_ready !== 1'b0) begin bad++; $display("FAIL full_dready: got=%b exp=0", dispatch_ready); end
      tick();
      // Full queue that issues this cycle still refuses the dispatch.
      drive_dispatch(mk_op(OPC_LOAD, 7'd0, 7'd0, 7'd99, 5'd9), 1'b1, 1'b1, 1'b0);
      fu_mem_ready = 1'b1;
      @(negedge clk);
      total++; if (dispatch_ready !== 1'b0) begin bad++; $display("FAIL full_issue_dready: got=%b exp=0", dispatch_ready); end
      total++; if (issued !== 1'b1) begin bad++; $display("FAIL full_issue: got=%b exp=1", issued); end
      tick();
      idle();
      for (int k = 7; k >= 1; k--) begin
         @(negedge clk);
         total++;
         if (issued !== 1'b1 || count !== 4'(k)) begin
            bad++; $display("FAIL drain_%0d: issued=%b count=%0d exp issued=1 count=%0d", k, issued, count, k);
         end
         tick();
      end
      for (int k = 0; k < DEPTH; k++) begin
         drive_dispatch(mk_op(OPC_STORE, 7'd0, 7'd0, 7'd0, 5'(k + 8)), 1'b1, 1'b1, 1'b1);
         @(negedge clk);
         total++;
         if (count !== ((k == 0) ? 4'd0 : 4'd1) || issued !== (k != 0)) begin
            bad++; $display("FAIL overlap_%0d: count=%0d issued=%b", k, count, issued);
         end
         tick();
      end
      idle();
      @(negedge clk);
      total++; if (issued !== 1'b1) begin bad++; $display("FAIL overlap_last: got=%b exp=1", issued); end
      tick();
      @(negedge clk);
      total++; if (count !== 4'd0) begin bad++; $display("FAIL overlap_count: got=%0d exp=0", count); end
      tick();
   endtask

   task automatic test_head_blocked();
      logic exp_iss;
      fu_mem_ready = 1'b1;
      drive_dispatch(mk_op(OPC_LOAD, 7'd20, 7'd0, 7'd50, 5'd4), 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      tick();
      drive_dispatch(mk_op(OPC_LOAD, 7'd0, 7'd0, 7'd51, 5'd5), 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      total++; if (issued !== 1'b0) begin bad++; $display("FAIL blocked_c1: got=%b exp=0", issued); end
      tick();
      idle();
      for (int c = 2; c <= 5; c++) begin
         wb_valid = '0;
         if (c == 3) begin wb_valid = 3'b010; wb_pd[1] = 7'd20; end
         @(negedge clk);
         case (c)
            2:       exp_iss = 1'b0;
            3:       exp_iss = BYPASS;
            4:       exp_iss = 1'b1;
            default: exp_iss = !BYPASS;
         endcase
         total++;
         if (issued !== exp_iss) begin
            bad++; $display("FAIL blocked_c%0d: issued=%b exp=%b", c, issued, exp_iss);
         end
         tick();
      end
      idle();
      @(negedge clk);
      total++; if (count !== 4'd0) begin bad++; $display("FAIL blocked_count: got=%0d exp=0", count); end
      tick();
   endtask

   task automatic test_mispredict();
      logic [4:0] tags [4];
      tags = '{5'd14, 5'd15, 5'd0, 5'd1};
      fu_mem_ready = 1'b0;
      rob_head = 5'd14;
      for (int k = 0; k < 4; k++) begin
         drive_dispatch(mk_op(OPC_LOAD, 7'd0, 7'd0, 7'(60 + k), tags[k]), 1'b1, 1'b1, 1'b1);
         tick();
      end
      idle();
      mispredict = 1'b1;
      mispredict_tag = 5'd15;
      fu_mem_ready = 1'b1;
      drive_dispatch(mk_op(OPC_LOAD, 7'd0, 7'd0, 7'd70, 5'd2), 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      total++; if (count !== 4'd4) begin bad++; $display("FAIL flush_pre_count: got=%0d exp=4", count); end
      total++; if (issued !== 1'b0) begin bad++; $display("FAIL flush_issued: got=%b exp=0", issued); end
      total++; if (dispatch_ready !== 1'b0) begin bad++; $display("FAIL flush_dready: got=%b exp=0", dispatch_ready); end
      tick();
      idle();
      void'(sb.pop_back());
      void'(sb.pop_back());
      @(negedge clk);
      total++; if (count !== 4'd2) begin bad++; $display("FAIL flush_count: got=%0d exp=2", count); end
      tick();
      @(negedge clk);
      total++; if (count !== 4'd1) begin bad++; $display("FAIL flush_drain: got=%0d exp=1", count); end
      tick();
      @(negedge clk);
      total++; if (count !== 4'd0 || issued !== 1'b0) begin
         bad++; $display("FAIL flush_empty: count=%0d issued=%b exp 0/0", count, issued);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      fu_mem_ready = 1'b0;
      rob_head = 5'd0;
      for (int k = 0; k < 5; k++) begin
         drive_dispatch(mk_op(OPC_LOAD, 7'd0, 7'd0, 7'(80 + k), 5'(k)), 1'b1, 1'b1, 1'b1);
         tick();
      end
      idle();
      @(negedge clk);
      total++; if (count !== 4'd5) begin bad++; $display("FAIL rst_pre_count: got=%0d exp=5", count); end
      #2;
      reset = 1'b1;
      fu_mem_ready = 1'b1;
      #1;
      total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_async_count: got=%0d exp=0", count); end
      total++; if (issued !== 1'b0) begin bad++; $display("FAIL rst_async_issued: got=%b exp=0", issued); end
      total++; if (dispatch_ready !== 1'b1) begin bad++; $display("FAIL rst_async_dready: got=%b exp=1", dispatch_ready); end
      sb.delete();
      tick();
      tick();
      reset = 1'b0;
      drive_dispatch(mk_op(OPC_LOAD, 7'd3, 7'd0, 7'd90, 5'd7), 1'b1, 1'b0, 1'b1);
      tick();
      idle();
      @(negedge clk);
      total++; if (issued !== 1'b1) begin bad++; $display("FAIL rst_after_issue: got=%b exp=1", issued); end
      tick();
   endtask

   initial begin
      test_reset();
      test_load();
      test_store_wakeup();
      test_full_wrap();
      test_head_blocked();
      test_mispredict();
      test_reset_mid();
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL sb_leftover: %0d ops never issued, exp 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
